// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential restoring divider.
//   state_e    : controller states (IDLE, RUN, DONE)
//   DEFAULT_N  : default operand width (divisor/quotient/remainder)
//   cnt_width  : iteration counter width for a given N
package seq_div_pkg;

    localparam int unsigned DEFAULT_N = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Counter must hold N-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seq_div_n32_div_step.sv
// One restoring-division step: compare the shifted partial remainder against
// the divisor and subtract when it fits. This is the single N+1-bit cell that
// the sequencer reuses every cycle (a full-adder chain plus a mux in a netlist).
//   r        in  N+1  shifted partial remainder {rem, next dividend bit}
//   d        in  N    divisor
//   rem_next out N    partial remainder for the next step
//   q_bit    out 1    quotient bit decided by this step
module div_step #(
    parameter int unsigned N = 32
) (
    input  logic [N:0]   r,
    input  logic [N-1:0] d,
    output logic [N-1:0] rem_next,
    output logic         q_bit
);

    logic [N:0] diff;
    logic [N:0] mux_out;
    logic       unused_top;

    assign q_bit   = (r >= {1'b0, d});
    assign diff    = r - {1'b0, d};
    assign mux_out = q_bit ? diff : r;

    // rem < d is invariant, so the selected value always fits in N bits.
    assign rem_next   = mux_out[N-1:0];
    assign unused_top = mux_out[N];

endmodule

// File: rtl/seq_div_n32.sv
// Sequential restoring divider: divides a 2N-bit dividend by an N-bit divisor,
// producing one quotient bit per clock (MSB first) over N cycles.
//   clk, rst   : clock (rising edge), synchronous active-high reset
//   start      : request; operands sampled on the accepting edge (IDLE/DONE)
//   dividend   : 2N-bit numerator
//   divisor    : N-bit denominator
//   busy       : high while iterating
//   done       : one-cycle pulse; results valid from this cycle
//   q_bit      : quotient bit decided this cycle, q_valid qualifies it
//   quotient   : final quotient (all ones on dbz/ovf)
//   remainder  : final remainder (dividend high half on dbz/ovf)
//   ovf        : dividend high half >= nonzero divisor (quotient would not fit)
//   dbz        : divisor was zero
module seq_div_n32
    import seq_div_pkg::*;
#(
    parameter int unsigned N     = DEFAULT_N,
    parameter int unsigned CNT_W = cnt_width(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2*N-1:0]   dividend,
    input  logic [N-1:0]     divisor,
    output logic             busy,
    output logic             done,
    output logic             q_bit,
    output logic             q_valid,
    output logic [N-1:0]     quotient,
    output logic [N-1:0]     remainder,
    output logic             ovf,
    output logic             dbz
);

    state_e             state;
    state_e             state_next;

    logic [N-1:0]       d_reg;
    logic [N-1:0]       rem_reg;
    logic [N-1:0]       lo_reg;
    logic [CNT_W-1:0]   cnt;
    logic [N-1:0]       quot_reg;
    logic               ovf_reg;
    logic               dbz_reg;

    logic [N-1:0]       div_hi;
    logic [N-1:0]       div_lo;
    logic               dbz_c;
    logic               ovf_c;
    logic               err_c;
    logic               accept_c;
    logic               last_c;

    logic [N:0]         step_r;
    logic [N-1:0]       step_rem;
    logic               step_q;

    // Operand split and error detection on the incoming request.
    assign div_hi   = dividend[2*N-1:N];
    assign div_lo   = dividend[N-1:0];
    assign dbz_c    = (divisor == '0);
    assign ovf_c    = !dbz_c && (div_hi >= divisor);
    assign err_c    = dbz_c || ovf_c;
    assign accept_c = start && (state != RUN);
    assign last_c   = (cnt == '0);

    // Bring down the next dividend bit into the partial remainder.
    assign step_r = {rem_reg, lo_reg[N-1]};

    div_step #(
        .N (N)
    ) u_step (
        .r        (step_r),
        .d        (d_reg),
        .rem_next (step_rem),
        .q_bit    (step_q)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and status decode.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        q_valid    = 1'b0;
        q_bit      = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next = err_c ? DONE : RUN;
                end
            end
            RUN: begin
                busy    = 1'b1;
                q_valid = 1'b1;
                q_bit   = step_q;
                if (last_c) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    state_next = err_c ? DONE : RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: load on accept, one restoring step per RUN cycle, hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_reg    <= '0;
            rem_reg  <= '0;
            lo_reg   <= '0;
            cnt      <= '0;
            quot_reg <= '0;
            ovf_reg  <= 1'b0;
            dbz_reg  <= 1'b0;
        end else if (accept_c) begin
            d_reg    <= divisor;
            rem_reg  <= div_hi;
            lo_reg   <= div_lo;
            cnt      <= CNT_W'(N - 1);
            quot_reg <= err_c ? '1 : '0;
            dbz_reg  <= dbz_c;
            ovf_reg  <= ovf_c;
        end else if (state == RUN) begin
            rem_reg  <= step_rem;
            lo_reg   <= {lo_reg[N-2:0], 1'b0};
            quot_reg <= {quot_reg[N-2:0], step_q};
            cnt      <= cnt - CNT_W'(1);
        end
    end

    assign quotient  = quot_reg;
    assign remainder = rem_reg;
    assign ovf       = ovf_reg;
    assign dbz       = dbz_reg;

endmodule
